// File: rtl/parking_pkg.sv
// Shared types and defaults for the parking barrier scheduler: state
// encoding, default timing/capacity values and the occupancy width.
package parking_pkg;

  localparam int STATE_W          = 3;
  localparam int OCC_W            = 4;
  localparam int DEF_CAPACITY     = 9;
  localparam int DEF_TIMEOUT      = 50;
  localparam int DEF_CLOSE_CYCLES = 4;

  typedef enum logic [STATE_W-1:0] {
    IDLE       = 3'd0,
    OPEN_ENTRY = 3'd1,
    OPEN_EXIT  = 3'd2,
    CLOSING    = 3'd3
  } state_e;

  // The timer is loaded with (period - 1), so it needs clog2 of the larger period.
  function automatic int timer_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/barrier_scheduler_if.sv
// Lane request/grant, sensor and status bundle of the barrier scheduler.
// slave = scheduler side, master = lanes/sensor/observer side.
interface barrier_scheduler_if;
  import parking_pkg::*;

  logic               entry_req;
  logic               exit_req;
  logic               car_passed;
  logic               entry_grant;
  logic               exit_grant;
  logic               barrier_open;
  logic [OCC_W-1:0]   occupancy;
  logic               full;
  logic               empty;
  logic               timeout_err;
  logic               exit_empty_err;
  logic [STATE_W-1:0] state;

  modport master (
    output entry_req, exit_req, car_passed,
    input  entry_grant, exit_grant, barrier_open, occupancy,
           full, empty, timeout_err, exit_empty_err, state
  );

  modport slave (
    input  entry_req, exit_req, car_passed,
    output entry_grant, exit_grant, barrier_open, occupancy,
           full, empty, timeout_err, exit_empty_err, state
  );

endinterface

// File: rtl/barrier_scheduler_gate_timer.sv
// gate_timer: loadable down-counter that saturates at zero; done is high
// while the count is zero. Shared by the open timeout and the closing hold.
module gate_timer #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         done
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/barrier_scheduler.sv
// Shared entry/exit barrier scheduler with occupancy tracking and open timeout.
// Define BARRIER_EXIT_PRIORITY_EN for fixed exit-over-entry priority instead of round-robin.
module barrier_scheduler
  import parking_pkg::*;
#(
  parameter int CAPACITY     = DEF_CAPACITY,
  parameter int TIMEOUT      = DEF_TIMEOUT,
  parameter int CLOSE_CYCLES = DEF_CLOSE_CYCLES
) (
  input logic                clk,
  input logic                reset,
  barrier_scheduler_if.slave bus
);

  localparam int               TW  = timer_width(TIMEOUT, CLOSE_CYCLES);
  localparam logic [OCC_W-1:0] CAP = OCC_W'(CAPACITY);

  state_e           st;
  logic [OCC_W-1:0] occ;
  logic             open_q;
  logic             entry_grant_q;
  logic             exit_grant_q;
  logic             timeout_q;
  logic             empty_err_q;

  logic             full_w;
  logic             empty_w;
  logic             entry_ok;
  logic             pick_exit;
  logic             pick_entry;
  logic             is_open;
  logic             go_open;
  logic             go_close;
  logic             timer_load;
  logic             timer_en;
  logic             timer_done;
  logic [TW-1:0]    timer_val;

  assign full_w   = (occ == CAP);
  assign empty_w  = (occ == '0);
  assign entry_ok = bus.entry_req && !full_w;

`ifdef BARRIER_EXIT_PRIORITY_EN
  assign pick_exit = bus.exit_req;
`else
  // last_entry set means entry was served last, so exit wins the next tie.
  logic last_entry;

  always_ff @(posedge clk) begin
    if (reset) begin
      last_entry <= 1'b1;
    end else if (go_open) begin
      last_entry <= pick_entry;
    end
  end

  assign pick_exit = bus.exit_req && (!entry_ok || last_entry);
`endif

  assign pick_entry = entry_ok && !pick_exit;
  assign is_open    = (st == OPEN_ENTRY) || (st == OPEN_EXIT);
  assign go_open    = (st == IDLE) && (pick_exit || pick_entry);
  assign go_close   = is_open && (bus.car_passed || timer_done);
  assign timer_load = go_open || go_close;
  assign timer_en   = is_open || (st == CLOSING);
  assign timer_val  = go_open ? TW'(TIMEOUT - 1) : TW'(CLOSE_CYCLES - 1);

  gate_timer #(
    .W (TW)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (timer_load),
    .load_val (timer_val),
    .en       (timer_en),
    .done     (timer_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      st            <= IDLE;
      occ           <= '0;
      open_q        <= 1'b0;
      entry_grant_q <= 1'b0;
      exit_grant_q  <= 1'b0;
      timeout_q     <= 1'b0;
      empty_err_q   <= 1'b0;
    end else begin
      entry_grant_q <= 1'b0;
      exit_grant_q  <= 1'b0;
      timeout_q     <= 1'b0;
      case (st)
        IDLE: begin
          if (pick_exit) begin
            st           <= OPEN_EXIT;
            exit_grant_q <= 1'b1;
            open_q       <= 1'b1;
          end else if (pick_entry) begin
            st            <= OPEN_ENTRY;
            entry_grant_q <= 1'b1;
            open_q        <= 1'b1;
          end
        end
        OPEN_ENTRY: begin
          // A car on the timeout cycle still counts; the timeout only fires without one.
          if (bus.car_passed) begin
            if (occ != CAP) begin
              occ <= occ + 1'b1;
            end
            st     <= CLOSING;
            open_q <= 1'b0;
          end else if (timer_done) begin
            st        <= CLOSING;
            open_q    <= 1'b0;
            timeout_q <= 1'b1;
          end
        end
        OPEN_EXIT: begin
          if (bus.car_passed) begin
            if (occ == '0) begin
              empty_err_q <= 1'b1;
            end else begin
              occ <= occ - 1'b1;
            end
            st     <= CLOSING;
            open_q <= 1'b0;
          end else if (timer_done) begin
            st        <= CLOSING;
            open_q    <= 1'b0;
            timeout_q <= 1'b1;
          end
        end
        CLOSING: begin
          if (timer_done) begin
            st <= IDLE;
          end
        end
        default: begin
          st     <= IDLE;
          open_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.entry_grant    = entry_grant_q;
  assign bus.exit_grant     = exit_grant_q;
  assign bus.barrier_open   = open_q;
  assign bus.occupancy      = occ;
  assign bus.full           = full_w;
  assign bus.empty          = empty_w;
  assign bus.timeout_err    = timeout_q;
  assign bus.exit_empty_err = empty_err_q;
  assign bus.state          = st;

endmodule

// File: tb/tb_barrier_scheduler.sv
// Scoreboard bench for barrier_scheduler: expected grant lanes are queued as
// requests are driven and compared by a monitor when a grant pulse appears.
module tb_barrier_scheduler;
  import parking_pkg::*;

  localparam int CAP_M = 9;
  localparam int TO_M  = 50;
  localparam int CL_M  = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  barrier_scheduler_if bus();

  barrier_scheduler dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int passes = 0;
  bit exp_q[$];   // 1 = exit lane expected, 0 = entry lane
  int m_occ = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) begin
    #1;
    if (bus.entry_grant || bus.exit_grant) begin
      bit e;
      checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL grant_unexpected: got entry=%0b exit=%0b, required no grant",
                 bus.entry_grant, bus.exit_grant);
      end else begin
        e = exp_q.pop_front();
        if (bus.exit_grant !== e || bus.entry_grant !== !e)
          $display("FAIL grant_lane: got entry=%0b exit=%0b, required exit=%0b entry=%0b",
                   bus.entry_grant, bus.exit_grant, e, !e);
        else
          passes++;
      end
    end
  end

  task automatic wait_grant(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      tick();
      if (bus.entry_grant || bus.exit_grant) ok = 1'b1;
    end
  endtask

  // From the cycle after a grant: pass one car, then walk the closing hold.
  task automatic run_pass(input bit is_exit, output bit closing_ok);
    bus.car_passed = 1'b1;
    tick();
    bus.car_passed = 1'b0;
    if (is_exit) begin
      if (m_occ > 0) m_occ--;
    end else begin
      if (m_occ < CAP_M) m_occ++;
    end
    closing_ok = 1'b1;
    for (int i = 0; i < CL_M; i++) begin
      if (bus.state !== 3'd3 || bus.barrier_open !== 1'b0) closing_ok = 1'b0;
      tick();
    end
    if (bus.state !== 3'd0) closing_ok = 1'b0;
  endtask

  task automatic serve(input bit is_exit, input bit release_req, output bit ok);
    bit g, c, open_ok;
    exp_q.push_back(is_exit);
    if (is_exit) bus.exit_req = 1'b1;
    else         bus.entry_req = 1'b1;
    wait_grant(g);
    if (release_req) begin
      if (is_exit) bus.exit_req = 1'b0;
      else         bus.entry_req = 1'b0;
    end
    open_ok = g && (bus.barrier_open === 1'b1) &&
              (bus.state === (is_exit ? 3'd2 : 3'd1));
    run_pass(is_exit, c);
    ok = open_ok && c;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (5) tick();
    reset = 1'b0;
    tick();
    m_occ = 0;
    checks++; if (bus.state !== 3'd0) $display("FAIL reset_state: got %0d required 0", bus.state); else passes++;
    checks++; if (bus.occupancy !== 4'd0) $display("FAIL reset_occ: got %0d required 0", bus.occupancy); else passes++;
    checks++; if (bus.barrier_open !== 1'b0) $display("FAIL reset_open: got %0b required 0", bus.barrier_open); else passes++;
    checks++; if ({bus.entry_grant, bus.exit_grant} !== 2'b00) $display("FAIL reset_grants: got %0b%0b required 00", bus.entry_grant, bus.exit_grant); else passes++;
    checks++; if ({bus.empty, bus.full} !== 2'b10) $display("FAIL reset_empty_full: got empty=%0b full=%0b required 1/0", bus.empty, bus.full); else passes++;
    checks++; if ({bus.timeout_err, bus.exit_empty_err} !== 2'b00) $display("FAIL reset_errs: got %0b%0b required 00", bus.timeout_err, bus.exit_empty_err); else passes++;
  endtask

  task automatic test_basic_entry();
    bit ok;
    serve(1'b0, 1'b1, ok);
    checks++; if (ok !== 1'b1) $display("FAIL basic_entry_seq: got %0b required 1", ok); else passes++;
    checks++; if (bus.occupancy !== 4'(m_occ) || m_occ != 1) $display("FAIL basic_entry_occ: got %0d required 1", bus.occupancy); else passes++;
    checks++; if (bus.empty !== 1'b0) $display("FAIL basic_entry_empty: got %0b required 0", bus.empty); else passes++;
  endtask

  task automatic test_full();
    bit ok, saw;
    for (int i = 0; i < 8; i++) begin
      serve(1'b0, 1'b1, ok);
      checks++; if (ok !== 1'b1) $display("FAIL fill_entry_%0d: got %0b required 1", i, ok); else passes++;
    end
    checks++; if (bus.occupancy !== 4'd9 || bus.full !== 1'b1) $display("FAIL full_flag: got occ=%0d full=%0b required 9/1", bus.occupancy, bus.full); else passes++;
    bus.entry_req = 1'b1;
    saw = 1'b0;
    repeat (30) begin
      tick();
      if (bus.entry_grant || bus.exit_grant) saw = 1'b1;
    end
    checks++; if (saw !== 1'b0 || bus.state !== 3'd0) $display("FAIL full_blocks_entry: got grant=%0b state=%0d required 0/0", saw, bus.state); else passes++;
    serve(1'b1, 1'b1, ok);
    checks++; if (ok !== 1'b1 || bus.occupancy !== 4'd8) $display("FAIL full_exit: got ok=%0b occ=%0d required 1/8", ok, bus.occupancy); else passes++;
    serve(1'b0, 1'b1, ok);
    checks++; if (ok !== 1'b1 || bus.occupancy !== 4'd9) $display("FAIL pending_entry: got ok=%0b occ=%0d required 1/9", ok, bus.occupancy); else passes++;
  endtask

  task automatic test_arbitration();
    bit ok;
    bit lanes [3];
`ifdef BARRIER_EXIT_PRIORITY_EN
    lanes[0] = 1'b1; lanes[1] = 1'b1; lanes[2] = 1'b1;
`else
    lanes[0] = 1'b1; lanes[1] = 1'b0; lanes[2] = 1'b1;
`endif
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    m_occ = 0;
    for (int i = 0; i < 3; i++) serve(1'b0, 1'b1, ok);
    checks++; if (bus.occupancy !== 4'd3) $display("FAIL arb_setup_occ: got %0d required 3", bus.occupancy); else passes++;
    bus.entry_req = 1'b1;
    bus.exit_req  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      serve(lanes[i], 1'b0, ok);
      checks++; if (ok !== 1'b1) $display("FAIL arb_round_%0d: got %0b required 1", i, ok); else passes++;
    end
    bus.entry_req = 1'b0;
    bus.exit_req  = 1'b0;
    checks++; if (bus.occupancy !== 4'(m_occ)) $display("FAIL arb_occ: got %0d required %0d", bus.occupancy, m_occ); else passes++;
  endtask

  task automatic test_timeout();
    bit g, stayed;
    int occ0;
    occ0 = m_occ;
    exp_q.push_back(1'b0);
    bus.entry_req = 1'b1;
    wait_grant(g);
    bus.entry_req = 1'b0;
    checks++; if (g !== 1'b1) $display("FAIL to_grant: got %0b required 1", g); else passes++;
    stayed = 1'b1;
    repeat (TO_M - 1) begin
      tick();
      if (bus.barrier_open !== 1'b1 || bus.timeout_err !== 1'b0) stayed = 1'b0;
    end
    checks++; if (stayed !== 1'b1) $display("FAIL to_open_window: got %0b required 1", stayed); else passes++;
    tick();
    checks++; if (bus.timeout_err !== 1'b1) $display("FAIL to_pulse: got %0b required 1", bus.timeout_err); else passes++;
    checks++; if (bus.state !== 3'd3 || bus.barrier_open !== 1'b0) $display("FAIL to_closing: got state=%0d open=%0b required 3/0", bus.state, bus.barrier_open); else passes++;
    checks++; if (bus.occupancy !== 4'(occ0)) $display("FAIL to_occ: got %0d required %0d", bus.occupancy, occ0); else passes++;
    tick();
    checks++; if (bus.timeout_err !== 1'b0) $display("FAIL to_one_cycle: got %0b required 0", bus.timeout_err); else passes++;
    repeat (CL_M - 1) tick();
    checks++; if (bus.state !== 3'd0) $display("FAIL to_idle: got %0d required 0", bus.state); else passes++;

    exp_q.push_back(1'b0);
    bus.entry_req = 1'b1;
    wait_grant(g);
    bus.entry_req = 1'b0;
    repeat (TO_M - 1) tick();
    bus.car_passed = 1'b1;
    tick();
    bus.car_passed = 1'b0;
    m_occ = occ0 + 1;
    checks++; if (bus.timeout_err !== 1'b0) $display("FAIL to_car_wins_err: got %0b required 0", bus.timeout_err); else passes++;
    checks++; if (bus.occupancy !== 4'(m_occ) || bus.state !== 3'd3) $display("FAIL to_car_wins_occ: got occ=%0d state=%0d required %0d/3", bus.occupancy, bus.state, m_occ); else passes++;
    repeat (CL_M) tick();
    checks++; if (bus.state !== 3'd0) $display("FAIL to_car_idle: got %0d required 0", bus.state); else passes++;
  endtask

  task automatic test_exit_empty();
    bit ok;
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    m_occ = 0;
    serve(1'b1, 1'b1, ok);
    checks++; if (ok !== 1'b1 || bus.occupancy !== 4'd0) $display("FAIL empty_exit: got ok=%0b occ=%0d required 1/0", ok, bus.occupancy); else passes++;
    checks++; if (bus.exit_empty_err !== 1'b1) $display("FAIL empty_err_set: got %0b required 1", bus.exit_empty_err); else passes++;
    serve(1'b0, 1'b1, ok);
    checks++; if (bus.exit_empty_err !== 1'b1 || bus.occupancy !== 4'd1) $display("FAIL empty_err_sticky: got err=%0b occ=%0d required 1/1", bus.exit_empty_err, bus.occupancy); else passes++;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    m_occ = 0;
    checks++; if (bus.exit_empty_err !== 1'b0) $display("FAIL empty_err_clear: got %0b required 0", bus.exit_empty_err); else passes++;
  endtask

  task automatic test_reset_open();
    bit ok, g;
    serve(1'b0, 1'b1, ok);
    exp_q.push_back(1'b1);
    bus.exit_req = 1'b1;
    wait_grant(g);
    bus.exit_req = 1'b0;
    checks++; if (g !== 1'b1 || bus.state !== 3'd2 || bus.barrier_open !== 1'b1) $display("FAIL ro_open_exit: got state=%0d open=%0b required 2/1", bus.state, bus.barrier_open); else passes++;
    reset = 1'b1;
    bus.car_passed = 1'b1;
    tick();
    reset = 1'b0;
    bus.car_passed = 1'b0;
    m_occ = 0;
    checks++; if (bus.barrier_open !== 1'b0 || bus.state !== 3'd0) $display("FAIL ro_closed: got open=%0b state=%0d required 0/0", bus.barrier_open, bus.state); else passes++;
    checks++; if (bus.occupancy !== 4'd0) $display("FAIL ro_occ: got %0d required 0", bus.occupancy); else passes++;
    // After reset the tie goes to exit in both arbitration modes.
    bus.entry_req = 1'b1;
    serve(1'b1, 1'b1, ok);
    bus.entry_req = 1'b0;
    checks++; if (ok !== 1'b1) $display("FAIL ro_exit_first: got %0b required 1", ok); else passes++;
  endtask

  initial begin
    reset          = 1'b1;
    bus.entry_req  = 1'b0;
    bus.exit_req   = 1'b0;
    bus.car_passed = 1'b0;
    test_reset();
    test_basic_entry();
    test_full();
    test_arbitration();
    test_timeout();
    test_exit_empty();
    test_reset_open();
    repeat (3) tick();
    checks++; if (exp_q.size() != 0) $display("FAIL grants_missing: got %0d pending required 0", exp_q.size()); else passes++;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/barrier_scheduler.md
BARRIER_SCHEDULER -- requirements
Module: barrier_scheduler

Interface
REQ-001 The block SHALL have parameter CAPACITY, default 9, meaning the maximum occupancy (1..15).
REQ-002 The block SHALL have parameter TIMEOUT, default 50, meaning the number of cycles the barrier may stay open without car_passed.
REQ-003 The block SHALL have parameter CLOSE_CYCLES, default 4, meaning the number of cycles the barrier is held closed before the next grant.
REQ-004 clk  input  1  the single clock; all logic is on the rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 entry_req  input  1  entry lane request, level, held by the requester until granted.
REQ-007 exit_req  input  1  exit lane request, level, held by the requester until granted.
REQ-008 car_passed  input  1  one-cycle pulse from the sensor-pair detector when a car has cleared the barrier.
REQ-009 entry_grant / exit_grant  output  1 each  one-cycle grant pulses.
REQ-010 barrier_open  output  1  opens the shared barrier.
REQ-011 occupancy  output  4  cars currently inside.
REQ-012 full / empty  output  1 each  occupancy==CAPACITY / occupancy==0.
REQ-013 timeout_err  output  1  one-cycle pulse on timeout.
REQ-014 exit_empty_err  output  1  sticky flag, cleared only by reset.
REQ-015 state  output  3  current FSM state, for debug.

Function
REQ-016 The FSM states SHALL be IDLE=0, OPEN_ENTRY=1, OPEN_EXIT=2 and CLOSING=3; codes 4-7 are unused and SHALL return to IDLE.
REQ-017 In IDLE, an eligible request sampled at edge N SHALL cause the grant pulse, the OPEN_* state and barrier_open=1 after edge N+1.
REQ-018 Entry SHALL be eligible only when full=0; an ineligible entry_req stays pending and is not dropped.
REQ-019 When both requests are eligible in IDLE, arbitration SHALL be round-robin, with the last-served lane losing; after reset exit has priority.
REQ-020 barrier_open SHALL be 1 exactly in OPEN_ENTRY and OPEN_EXIT.
REQ-021 car_passed in OPEN_ENTRY SHALL increment occupancy at the same edge and move the FSM to CLOSING.
REQ-022 car_passed in OPEN_EXIT SHALL decrement occupancy at the same edge and move the FSM to CLOSING.
REQ-023 car_passed in IDLE or CLOSING SHALL be ignored.
REQ-024 Exit granted at occupancy 0 SHALL saturate occupancy at 0 and set exit_empty_err when car_passed arrives.
REQ-025 Occupancy SHALL never exceed CAPACITY; with no other increment source, entry at full is unreachable.
REQ-026 The open timer SHALL count cycles spent in an OPEN_* state; when it reaches TIMEOUT without car_passed, the FSM SHALL go to CLOSING with occupancy unchanged and pulse timeout_err for 1 cycle.
REQ-027 If car_passed coincides with the timeout cycle, car_passed SHALL win: the count is applied and timeout_err is not asserted.
REQ-028 CLOSING SHALL last exactly CLOSE_CYCLES cycles and then return to IDLE; requests are not granted during CLOSING.
REQ-029 full and empty SHALL be combinational decodes of the registered occupancy.

Reset
REQ-030 While reset=1 at an edge, the block SHALL set state=IDLE, occupancy=0, barrier_open=0, both grants=0, timeout_err=0, exit_empty_err=0, clear the timers and set the round-robin pointer to favour exit.
REQ-031 Reset mid-operation, including from an OPEN_* state, SHALL close the barrier at that edge and discard any in-flight car.

Configuration
REQ-032 With macro BARRIER_EXIT_PRIORITY_EN defined, arbitration SHALL be fixed-priority, with exit always winning over entry.
REQ-033 Without BARRIER_EXIT_PRIORITY_EN, arbitration SHALL be the round-robin of REQ-019.

Structure
REQ-034 Shared package parking_pkg SHALL hold the state encoding constants (3-bit), the default CAPACITY/TIMEOUT/CLOSE_CYCLES values and the occupancy width (4).
REQ-035 A sub-module gate_timer (loadable down-counter with a done output) SHALL be instanced once and reused for both the open timeout and the CLOSING hold.

Verification
REQ-036 Bench: reset 5 cycles; entry_req=1 -> entry_grant pulse next cycle, barrier_open=1, state=1; car_passed pulse -> occupancy=1, state=3 for 4 cycles, then state=0.
REQ-037 Bench: 9 entries (occupancy=9, full=1); hold entry_req -> no grant; assert exit_req -> exit served, occupancy=8, then the pending entry is granted.
REQ-038 Bench: entry_req and exit_req both held from IDLE with occupancy=3 -> exit, then entry, then exit alternately; repeat with BARRIER_EXIT_PRIORITY_EN -> exit every time.
REQ-039 Bench: grant entry, no car_passed -> timeout_err pulse after 50 open cycles, occupancy unchanged; a second run with car_passed on cycle 50 -> occupancy+1 and no timeout_err.
REQ-040 Bench: exit at occupancy=0 with car_passed -> occupancy=0, exit_empty_err=1 sticky until reset.
REQ-041 Bench: reset asserted during OPEN_EXIT -> next edge gives barrier_open=0, state=0, occupancy=0.
